// File: rtl/oss_hal_regbank_pkg.sv
// Shared constants and types for the OPS-SAT HAL register bank.
package oss_hal_pkg;

  // System register word addresses
  localparam int unsigned ADDR_VERSION    = 32'h0000_0000;
  localparam int unsigned ADDR_HIGHWATER  = 32'h0000_0001;
  localparam int unsigned ADDR_BADCNT     = 32'h0000_0002;
  localparam int unsigned ADDR_EVT_STICKY = 32'h0000_0003;
  localparam int unsigned ADDR_EVT_MASK   = 32'h0000_0004;

  // Base addresses of the read/write and read-only register windows
  localparam int unsigned RW_BASE = 32'h0000_0010;
  localparam int unsigned RO_BASE = 32'h0000_0020;

  // Value returned for reads of unmapped addresses
  localparam logic [31:0] BAD_READ_VALUE = 32'hDEAD_BEEF;

  // Address decode classes
  typedef enum logic [1:0] {
    DEC_SYS = 2'd0,
    DEC_RW  = 2'd1,
    DEC_RO  = 2'd2,
    DEC_BAD = 2'd3
  } dec_class_e;

endpackage

// File: rtl/oss_hal_regbank_evt_sticky.sv
// Sticky event capture with write-1-to-clear, mask register and a
// registered interrupt. A new event beats a clear on the same bit.
module oss_hal_evt_sticky #(
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clr_en,
  input  logic [NUM_EVT-1:0] clr_bits,
  input  logic               mask_we,
  input  logic [NUM_EVT-1:0] mask_data,
  output logic [NUM_EVT-1:0] sticky,
  output logic [NUM_EVT-1:0] mask,
  output logic               irq
);

  logic [NUM_EVT-1:0] sticky_r;
  logic [NUM_EVT-1:0] mask_r;
  logic [NUM_EVT-1:0] clr_s;
  logic               irq_r;

  // Bits to clear this cycle, only when a W1C write is in progress
  always_comb begin
    clr_s = '0;
    if (clr_en) begin
      clr_s = clr_bits;
    end else begin
      clr_s = '0;
    end
  end

  // Sticky capture, mask update and interrupt register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky_r <= '0;
      mask_r   <= '0;
      irq_r    <= 1'b0;
    end else begin
      sticky_r <= (sticky_r & ~clr_s) | evt;
      if (mask_we) begin
        mask_r <= mask_data;
      end
      irq_r <= |(sticky_r & mask_r);
    end
  end

  assign sticky = sticky_r;
  assign mask   = mask_r;
  assign irq    = irq_r;

endmodule

// File: rtl/oss_hal_regbank.sv
// Parametrised HAL register bank: control/status registers, sticky events,
// bad-access counter and registered read port.
// Optional macro OSS_HAL_HIGHWATER_EN adds the address high-water register;
// without it address 0x01 reads as zero.
module oss_hal_regbank #(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 32,
  parameter int          NUM_RW  = 4,
  parameter int          NUM_RO  = 4,
  parameter int          NUM_EVT = 8,
  parameter logic [31:0] VERSION = 32'h0055_0002
) (
  input  logic                     hal_clk,
  input  logic                     hal_reset_n,
  input  logic                     reg_itf_write_in,
  input  logic                     reg_itf_read_in,
  input  logic [ADDR_W-1:0]        reg_itf_addr_in,
  input  logic [DATA_W-1:0]        reg_itf_writedata_in,
  output logic [DATA_W-1:0]        reg_itf_readdata_out,
  output logic                     reg_itf_readvalid_out,
  output logic [NUM_RW*DATA_W-1:0] rw_regs_out,
  output logic [NUM_RW-1:0]        wr_pulse_out,
  input  logic [NUM_RO*DATA_W-1:0] ro_regs_in,
  input  logic [NUM_EVT-1:0]       evt_in,
  output logic                     evt_irq_out
);
  import oss_hal_pkg::*;

  localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(ADDR_VERSION);
  localparam logic [ADDR_W-1:0] A_HW      = ADDR_W'(ADDR_HIGHWATER);
  localparam logic [ADDR_W-1:0] A_BADCNT  = ADDR_W'(ADDR_BADCNT);
  localparam logic [ADDR_W-1:0] A_STICKY  = ADDR_W'(ADDR_EVT_STICKY);
  localparam logic [ADDR_W-1:0] A_MASK    = ADDR_W'(ADDR_EVT_MASK);
  localparam logic [ADDR_W-1:0] A_RW      = ADDR_W'(RW_BASE);
  localparam logic [ADDR_W-1:0] A_RO      = ADDR_W'(RO_BASE);

  logic [DATA_W-1:0]  rw_r [NUM_RW];
  logic [DATA_W-1:0]  rd_data_r;
  logic               rd_valid_r;
  logic [NUM_RW-1:0]  wr_pulse_r;
  logic [DATA_W-1:0]  badcnt_r;

  dec_class_e         dec_s;
  logic               wr_ok_s;
  logic               bad_inc_s;
  logic               cnt_clr_s;
  logic               sticky_clr_s;
  logic               mask_we_s;
  logic [NUM_RW-1:0]  rw_we_s;
  logic [DATA_W-1:0]  rd_mux_s;
  logic [NUM_EVT-1:0] sticky_s;
  logic [NUM_EVT-1:0] mask_s;
  logic               irq_s;
  logic [ADDR_W-1:0]  hw_s;

  // Classify the current address
  always_comb begin
    dec_s = DEC_BAD;
    if (reg_itf_addr_in <= A_MASK) begin
      dec_s = DEC_SYS;
    end else if (reg_itf_addr_in >= A_RW && reg_itf_addr_in < A_RW + ADDR_W'(NUM_RW)) begin
      dec_s = DEC_RW;
    end else if (reg_itf_addr_in >= A_RO && reg_itf_addr_in < A_RO + ADDR_W'(NUM_RO)) begin
      dec_s = DEC_RO;
    end else begin
      dec_s = DEC_BAD;
    end
  end

  // Write legality, write enables and bad-access detection
  always_comb begin
    wr_ok_s = 1'b0;
    case (dec_s)
      DEC_SYS: wr_ok_s = (reg_itf_addr_in == A_BADCNT) || (reg_itf_addr_in == A_STICKY) ||
                         (reg_itf_addr_in == A_MASK);
      DEC_RW:  wr_ok_s = 1'b1;
      DEC_RO:  wr_ok_s = 1'b0;
      default: wr_ok_s = 1'b0;
    endcase
    bad_inc_s    = (reg_itf_write_in && !wr_ok_s) || (reg_itf_read_in && (dec_s == DEC_BAD));
    cnt_clr_s    = reg_itf_write_in && (reg_itf_addr_in == A_BADCNT);
    sticky_clr_s = reg_itf_write_in && (reg_itf_addr_in == A_STICKY);
    mask_we_s    = reg_itf_write_in && (reg_itf_addr_in == A_MASK);
    rw_we_s      = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      rw_we_s[k] = reg_itf_write_in && (reg_itf_addr_in == A_RW + ADDR_W'(k));
    end
  end

  // Read data multiplexer, sampling state before any same-cycle write
  always_comb begin
    rd_mux_s = DATA_W'(BAD_READ_VALUE);
    case (dec_s)
      DEC_SYS: begin
        if (reg_itf_addr_in == A_VERSION) begin
          rd_mux_s = DATA_W'(VERSION);
        end else if (reg_itf_addr_in == A_HW) begin
          rd_mux_s = DATA_W'(hw_s);
        end else if (reg_itf_addr_in == A_BADCNT) begin
          rd_mux_s = badcnt_r;
        end else if (reg_itf_addr_in == A_STICKY) begin
          rd_mux_s = DATA_W'(sticky_s);
        end else begin
          rd_mux_s = DATA_W'(mask_s);
        end
      end
      DEC_RW: begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (reg_itf_addr_in == A_RW + ADDR_W'(k)) begin
            rd_mux_s = rw_r[k];
          end
        end
      end
      DEC_RO: begin
        for (int k = 0; k < NUM_RO; k++) begin
          if (reg_itf_addr_in == A_RO + ADDR_W'(k)) begin
            rd_mux_s = ro_regs_in[k*DATA_W +: DATA_W];
          end
        end
      end
      default: rd_mux_s = DATA_W'(BAD_READ_VALUE);
    endcase
  end

  // Read port, control registers, write strobes and bad-access counter
  always_ff @(posedge hal_clk) begin
    if (!hal_reset_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      wr_pulse_r <= '0;
      badcnt_r   <= '0;
      for (int k = 0; k < NUM_RW; k++) begin
        rw_r[k] <= '0;
      end
    end else begin
      rd_valid_r <= reg_itf_read_in;
      if (reg_itf_read_in) begin
        rd_data_r <= rd_mux_s;
      end
      wr_pulse_r <= rw_we_s;
      for (int k = 0; k < NUM_RW; k++) begin
        if (rw_we_s[k]) begin
          rw_r[k] <= reg_itf_writedata_in;
        end
      end
      if (cnt_clr_s) begin
        badcnt_r <= '0;
      end else if (bad_inc_s && (badcnt_r != {DATA_W{1'b1}})) begin
        badcnt_r <= badcnt_r + DATA_W'(1);
      end
    end
  end

`ifdef OSS_HAL_HIGHWATER_EN
  logic [ADDR_W-1:0] hw_r;

  // Track the highest address seen on any access
  always_ff @(posedge hal_clk) begin
    if (!hal_reset_n) begin
      hw_r <= '0;
    end else if ((reg_itf_read_in || reg_itf_write_in) && (reg_itf_addr_in > hw_r)) begin
      hw_r <= reg_itf_addr_in;
    end
  end

  assign hw_s = hw_r;
`else
  assign hw_s = '0;
`endif

  oss_hal_evt_sticky #(
    .NUM_EVT (NUM_EVT)
  ) u_evt (
    .clk       (hal_clk),
    .reset_n   (hal_reset_n),
    .evt       (evt_in),
    .clr_en    (sticky_clr_s),
    .clr_bits  (reg_itf_writedata_in[NUM_EVT-1:0]),
    .mask_we   (mask_we_s),
    .mask_data (reg_itf_writedata_in[NUM_EVT-1:0]),
    .sticky    (sticky_s),
    .mask      (mask_s),
    .irq       (irq_s)
  );

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_regs_out[g*DATA_W +: DATA_W] = rw_r[g];
  end

  assign reg_itf_readdata_out  = rd_data_r;
  assign reg_itf_readvalid_out = rd_valid_r;
  assign wr_pulse_out          = wr_pulse_r;
  assign evt_irq_out           = irq_s;

endmodule
